load_store_unit: RTL

//  Responder side of the execute-stage load/store handshake: accepts one command at a time
//  (load, store, atomic, TLB invalidate), performs aligned word-bus accesses to the D-side

---
 rtl/load_store_unit_pkg.sv | 94 +++++++++
 rtl/load_store_unit_atomic_alu.sv | 30 +++
 rtl/load_store_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: command/size/AMO encodings,
// FSM state constants, and byte-lane helpers for alignment, enables and extraction.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        CmdLoad       = 2'd0,
        CmdStore      = 2'd1,
        CmdAtomic     = 2'd2,
        CmdInvalidate = 2'd3
    } lsu_cmd_e;

    // Bit 2 marks unsigned loads; bits [1:0] carry the size.
    typedef enum logic [2:0] {
        LsByte  = 3'd0,
        LsHalf  = 3'd1,
        LsWord  = 3'd2,
        LsByteU = 3'd4,
        LsHalfU = 3'd5
    } lsu_type_e;

    typedef enum logic [3:0] {
        AmoLr   = 4'd0,
        AmoSc   = 4'd1,
        AmoSwap = 4'd2,
        AmoAdd  = 4'd3,
        AmoXor  = 4'd4,
        AmoAnd  = 4'd5,
        AmoOr   = 4'd6,
        AmoMin  = 4'd7,
        AmoMax  = 4'd8,
        AmoMinu = 4'd9,
        AmoMaxu = 4'd10
    } lsu_amo_e;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // 0 = byte, 1 = half, 2 = word
    function automatic logic [1:0] lsu_size(input lsu_type_e t);
        case (t)
            LsByte, LsByteU: return 2'd0;
            LsHalf, LsHalfU: return 2'd1;
            default:         return 2'd2;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_cmd_e cmd, input lsu_type_e t,
                                            input logic [1:0] off);
        case (cmd)
            CmdAtomic:     return off != 2'b00;
            CmdInvalidate: return 1'b0;
            default: begin
                case (lsu_size(t))
                    2'd0:    return 1'b0;
                    2'd1:    return off[0];
                    default: return off != 2'b00;
                endcase
            end
        endcase
    endfunction

    function automatic logic [3:0] lsu_byte_enable(input lsu_type_e t, input logic [1:0] off);
        case (lsu_size(t))
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow data across the word so every lane carries it.
    function automatic logic [31:0] lsu_store_data(input lsu_type_e t, input logic [31:0] v);
        case (lsu_size(t))
            2'd0:    return {4{v[7:0]}};
            2'd1:    return {2{v[15:0]}};
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] lsu_extract(input lsu_type_e t, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (t)
            LsByte:  return {{24{sh[7]}}, sh[7:0]};
            LsByteU: return {24'b0, sh[7:0]};
            LsHalf:  return {{16{sh[15]}}, sh[15:0]};
            LsHalfU: return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_atomic_alu.sv
// Combinational AMO datapath: new memory word from the old word and the operand.
// Only present when LSU_ATOMIC_EN is defined.
`ifdef LSU_ATOMIC_EN
module load_store_unit_atomic_alu
    import load_store_unit_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] operand_i,
    input  lsu_amo_e    atomic_type_i,
    output logic [31:0] new_o
);

    // Select the read-modify-write result
    always_comb begin
        new_o = operand_i;
        case (atomic_type_i)
            AmoAdd:  new_o = old_i + operand_i;
            AmoXor:  new_o = old_i ^ operand_i;
            AmoAnd:  new_o = old_i & operand_i;
            AmoOr:   new_o = old_i | operand_i;
            AmoMin:  new_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
            AmoMax:  new_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
            AmoMinu: new_o = (old_i < operand_i) ? old_i : operand_i;
            AmoMaxu: new_o = (old_i > operand_i) ? old_i : operand_i;
            default: new_o = operand_i;
        endcase
    end

endmodule
`endif

// File: rtl/load_store_unit.sv
// Load/store unit: one command at a time, word-aligned D-side bus accesses, done/fault/result.
// Define LSU_ATOMIC_EN to enable LR/SC reservations and AMOs; otherwise Atomic faults.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  lsu_cmd_e    command,
    input  lsu_type_e   loadStoreType,
    input  lsu_amo_e    atomicType,
    input  logic        invalidateTlb,
    input  logic [31:0] addr,
    input  logic [31:0] storeRegValue,
    output logic        done,
    output logic        fault,
    output logic [31:0] result,
    output logic        memReq,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [3:0]  memByteEnable,
    output logic [31:0] memWriteValue,
    input  logic        memReady,
    input  logic [31:0] memReadValue,
    input  logic        memError
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

    logic [1:0]      state_q, state_d;
    lsu_type_e       ls_type_q, ls_type_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     pend_q, pend_d;   // result reported after the write phase
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic [31:0]     result_q, result_d;
    logic [CntW-1:0] cnt_inc;
    logic            timeout_hit;

`ifdef LSU_ATOMIC_EN
    logic            atomic_q, atomic_d;
    lsu_amo_e        amo_q, amo_d;
    logic            resv_valid_q, resv_valid_d;
    logic [29:0]     resv_addr_q, resv_addr_d;
    logic [31:0]     amo_new;
    logic            resv_hit;

    assign resv_hit = resv_valid_q && (resv_addr_q == addr[31:2]);

    load_store_unit_atomic_alu u_atomic_alu (
        .old_i         (memReadValue),
        .operand_i     (wdata_q),
        .atomic_type_i (amo_q),
        .new_o         (amo_new)
    );
`else
    logic unused_atomic;
    assign unused_atomic = ^{atomicType, invalidateTlb};
`endif

    assign cnt_inc     = cnt_q + CntW'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TimeoutVal);

    // Next-state: accept, bus phases, timeout and completion bookkeeping
    always_comb begin
        state_d   = state_q;
        ls_type_d = ls_type_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        result_d  = result_q;
`ifdef LSU_ATOMIC_EN
        atomic_d     = atomic_q;
        amo_d        = amo_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    ls_type_d = loadStoreType;
                    addr_d    = addr;
                    be_d      = lsu_byte_enable(loadStoreType, addr[1:0]);
                    wdata_d   = lsu_store_data(loadStoreType, storeRegValue);
                    pend_d    = '0;
                    cnt_d     = '0;
                    fault_d   = 1'b0;
`ifdef LSU_ATOMIC_EN
                    atomic_d  = (command == CmdAtomic);
                    amo_d     = atomicType;
`endif
                    if (lsu_misaligned(command, loadStoreType, addr[1:0])) begin
                        state_d  = StDone;
                        fault_d  = 1'b1;
                        result_d = '0;
                    end else begin
                        unique case (command)
                            CmdLoad: state_d = StRead;
                            CmdStore: begin
                                state_d = StWrite;
`ifdef LSU_ATOMIC_EN
                                if (resv_hit) resv_valid_d = 1'b0;
`endif
                            end
                            CmdInvalidate: begin
                                state_d  = StDone;
                                result_d = '0;
`ifdef LSU_ATOMIC_EN
                                if (invalidateTlb) resv_valid_d = 1'b0;
`endif
                            end
                            CmdAtomic: begin
`ifdef LSU_ATOMIC_EN
                                be_d    = 4'hF;
                                wdata_d = storeRegValue;
                                if (atomicType == AmoSc) begin
                                    resv_valid_d = 1'b0;
                                    if (resv_hit) begin
                                        state_d = StWrite;
                                    end else begin
                                        state_d  = StDone;
                                        result_d = 32'd1;
                                    end
                                end else begin
                                    state_d = StRead;
                                end
`else
                                state_d  = StDone;
                                fault_d  = 1'b1;
                                result_d = '0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StRead: begin
                if (memReady) begin
                    if (memError) begin
                        state_d  = StDone;
                        fault_d  = 1'b1;
                        result_d = '0;
`ifdef LSU_ATOMIC_EN
                    end else if (atomic_q && (amo_q != AmoLr)) begin
                        pend_d  = memReadValue;
                        wdata_d = amo_new;
                        state_d = StWrite;
                    end else if (atomic_q) begin
                        state_d      = StDone;
                        result_d     = memReadValue;
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q[31:2];
`endif
                    end else begin
                        state_d  = StDone;
                        result_d = lsu_extract(ls_type_q, addr_q[1:0], memReadValue);
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d  = StDone;
                        fault_d  = 1'b1;
                        result_d = '0;
                    end
                end
            end
            StWrite: begin
                if (memReady) begin
                    state_d  = StDone;
                    fault_d  = memError;
                    result_d = memError ? '0 : pend_q;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d  = StDone;
                        fault_d  = 1'b1;
                        result_d = '0;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            ls_type_q <= LsByte;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            result_q  <= '0;
`ifdef LSU_ATOMIC_EN
            atomic_q     <= 1'b0;
            amo_q        <= AmoLr;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ls_type_q <= ls_type_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            result_q  <= result_d;
`ifdef LSU_ATOMIC_EN
            atomic_q     <= atomic_d;
            amo_q        <= amo_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
`endif
        end
    end

    assign done          = (state_q == StDone);
    assign fault         = done && fault_q;
    assign result        = result_q;
    assign memReq        = (state_q == StRead) || (state_q == StWrite);
    assign memWrite      = (state_q == StWrite);
    assign memAddr       = {addr_q[31:2], 2'b00};
    assign memByteEnable = memWrite ? be_q : 4'b0000;
    assign memWriteValue = wdata_q;

endmodule
